// File: rtl/fsc_xor_pipe.sv
// fsc_xor_pipe: two-stage N-lane XOR reducer with a valid/ready handshake.
// Stage 1 folds the masked lanes of one beat into a single W-bit word.
// Stage 2 either forwards that word directly (per-beat mode) or XOR-folds
// successive words until a last marker (packet mode). It also counts, with
// saturation, how many beats went into each result. One advance enable
// stalls both stages together while a result is waiting on the consumer.
module fsc_xor_pipe #(
  parameter int N     = 6,
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic [N*W-1:0]   idata,
  input  logic [N-1:0]     imask,
  input  logic             imode,
  input  logic             ilast,
  input  logic             ivalid,
  output logic             oready,
  output logic [W-1:0]     oq,
  output logic [CNT_W-1:0] ocnt,
  output logic             ovalid,
  input  logic             iready
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic             en;
  logic             accept;
  logic [W-1:0]     lane_xor;
  logic             s1_valid;
  logic             s1_mode;
  logic             s1_last;
  logic [W-1:0]     s1_data;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             eff_mode;

  assign en       = !ovalid || iready;
  assign oready   = en;
  assign accept   = ivalid && en;
  assign cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign eff_mode = (state == ACCUM) ? 1'b1 : s1_mode;

  // Fold the enabled lanes of the incoming beat into one word.
  always_comb begin
    lane_xor = '0;
    for (int k = 0; k < N; k++) begin
      lane_xor = lane_xor ^ (idata[k*W +: W] & {W{imask[k]}});
    end
  end

  // Stage 1: capture the reduced beat and its packet controls.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_mode  <= imode;
      s1_last  <= ilast;
      if (accept) begin
        s1_data <= lane_xor;
      end
    end
  end

  // Stage 2: emit per-beat results, or fold a packet until its last beat.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      oq     <= '0;
      ocnt   <= '0;
      ovalid <= 1'b0;
    end else if (en) begin
      if (!s1_valid) begin
        ovalid <= 1'b0;
      end else if (!eff_mode) begin
        oq     <= s1_data;
        ocnt   <= CNT_ONE;
        ovalid <= 1'b1;
      end else if (!s1_last) begin
        acc    <= acc ^ s1_data;
        cnt    <= cnt_next;
        state  <= ACCUM;
        ovalid <= 1'b0;
      end else begin
        oq     <= acc ^ s1_data;
        ocnt   <= cnt_next;
        ovalid <= 1'b1;
        acc    <= '0;
        cnt    <= '0;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fsc_xor_pipe.sv
// tb_fsc_xor_pipe: randomized and directed stimulus for fsc_xor_pipe.
// Each accepted beat goes to a packet-level reference model, which queues
// the results it expects. An independent monitor pops and compares them
// whenever the DUT hands a result to the consumer.
module tb_fsc_xor_pipe;

  localparam int N     = 6;
  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [W-1:0]     q;
    logic [CNT_W-1:0] c;
  } exp_t;

  logic             iclk;
  logic             irst_n;
  logic [N*W-1:0]   idata;
  logic [N-1:0]     imask;
  logic             imode;
  logic             ilast;
  logic             ivalid;
  logic             oready;
  logic [W-1:0]     oq;
  logic [CNT_W-1:0] ocnt;
  logic             ovalid;
  logic             iready;

  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int stall_left = 0;
  bit random_bp = 0;

  exp_t exp_q[$];
  bit   m_in_pkt = 0;
  logic [W-1:0] m_acc = '0;
  int   m_cnt = 0;

  fsc_xor_pipe #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .idata  (idata),
    .imask  (imask),
    .imode  (imode),
    .ilast  (ilast),
    .ivalid (ivalid),
    .oready (oready),
    .oq     (oq),
    .ocnt   (ocnt),
    .ovalid (ovalid),
    .iready (iready)
  );

  // Free-running clock, period 10.
  initial begin
    iclk = 1'b0;
    forever #5 iclk = ~iclk;
  end

  // Hard stop in case the run loses its way.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: acts on one accepted beat at packet level.
  task automatic model_accept(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic md, input logic lst);
    logic [W-1:0] x;
    exp_t e;
    x = '0;
    for (int k = 0; k < N; k++) begin
      if (m[k]) x = x ^ d[k*W +: W];
    end
    if (!m_in_pkt && !md) begin
      e.q = x;
      e.c = CNT_W'(1);
      exp_q.push_back(e);
    end else begin
      m_acc = m_acc ^ x;
      m_cnt = m_cnt + 1;
      if (lst) begin
        e.q = m_acc;
        e.c = CNT_W'((m_cnt > CNT_SAT) ? CNT_SAT : m_cnt);
        exp_q.push_back(e);
        m_acc = '0;
        m_cnt = 0;
        m_in_pkt = 0;
      end else begin
        m_in_pkt = 1;
      end
    end
  endtask

  task automatic update_ready();
    if (stall_left > 0) begin
      iready = 1'b0;
      stall_left--;
    end else if (random_bp) begin
      iready = ($urandom_range(0, 3) != 0);
    end else begin
      iready = 1'b1;
    end
  endtask

  // Present one beat and hold it until the DUT accepts it.
  task automatic apply_stimulus(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic md, input logic lst);
    int waited = 0;
    @(negedge iclk);
    idata = d; imask = m; imode = md; ilast = lst; ivalid = 1'b1;
    update_ready();
    #1;
    while (!oready) begin
      if (waited > 200) begin
        check_output("accept_timeout", 32'(oready), 32'd1);
        break;
      end
      @(negedge iclk);
      update_ready();
      #1;
      waited++;
    end
    if (oready) model_accept(d, m, md, lst);
    @(posedge iclk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge iclk);
      ivalid = 1'b0;
      update_ready();
      @(posedge iclk);
    end
  endtask

  // Run with an open consumer until every expected result has come out.
  task automatic drain();
    int budget = 0;
    random_bp = 0;
    stall_left = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      idle(1);
      budget++;
    end
    check_output("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(3);
  endtask

  function automatic logic [N*W-1:0] lane0(input logic [W-1:0] v);
    logic [N*W-1:0] d;
    d = '0;
    d[W-1:0] = v;
    return d;
  endfunction

  // Monitor: compare every handed-off result and the stability of held ones.
  initial begin
    exp_t e;
    bit held_valid = 0;
    logic [W-1:0] held_q = '0;
    logic [CNT_W-1:0] held_c = '0;
    forever begin
      @(negedge iclk);
      #2;
      if (irst_n) begin
        if (held_valid) begin
          check_output("held_ovalid", 32'(ovalid), 32'd1);
          check_output("held_oq", 32'(oq), 32'(held_q));
          check_output("held_ocnt", 32'(ocnt), 32'(held_c));
        end
        if (ovalid && !iready) begin
          check_output("blocked_oready", 32'(oready), 32'd0);
          held_valid = 1;
          held_q = oq;
          held_c = ocnt;
        end else begin
          held_valid = 0;
        end
        if (ovalid && iready) begin
          out_count++;
          if (exp_q.size() == 0) begin
            check_output("unexpected_output", 32'(oq), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_output("result_oq", 32'(oq), 32'(e.q));
            check_output("result_ocnt", 32'(ocnt), 32'(e.c));
          end
        end
      end else begin
        held_valid = 0;
      end
    end
  end

  // Main sequence: directed scenarios first, then a random soak.
  initial begin
    int base;
    logic [N*W-1:0] d;
    logic lst;
    irst_n = 1'b0;
    idata = '0; imask = '0; imode = 1'b0; ilast = 1'b0; ivalid = 1'b0; iready = 1'b1;
    #3;
    check_output("reset_ovalid", 32'(ovalid), 32'd0);
    check_output("reset_oready", 32'(oready), 32'd1);
    check_output("reset_oq", 32'(oq), 32'd0);
    check_output("reset_ocnt", 32'(ocnt), 32'd0);
    @(negedge iclk);
    irst_n = 1'b1;
    @(posedge iclk);

    // Basic reduction with latency check.
    apply_stimulus(24'h538421, 6'h3F, 1'b0, 1'b0);
    @(negedge iclk);
    ivalid = 1'b0;
    #1;
    check_output("latency_early", 32'(ovalid), 32'd0);
    @(negedge iclk);
    #1;
    check_output("latency_ovalid", 32'(ovalid), 32'd1);
    check_output("basic_oq", 32'(oq), 32'h9);
    check_output("basic_ocnt", 32'(ocnt), 32'd1);
    drain();

    // Masking.
    apply_stimulus(24'h538421, 6'b000011, 1'b0, 1'b0);
    apply_stimulus(24'h538421, 6'b000000, 1'b0, 1'b1);
    drain();

    // Accumulate, with imode dropped mid-packet.
    base = out_count;
    apply_stimulus(lane0(4'h1), 6'h3F, 1'b1, 1'b0);
    apply_stimulus(lane0(4'h2), 6'h3F, 1'b0, 1'b0);
    apply_stimulus(lane0(4'h4), 6'h3F, 1'b0, 1'b1);
    drain();
    check_output("accum_outputs", 32'(out_count - base), 32'd1);

    // Backpressure mid-stream.
    base = out_count;
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) stall_left = 3;
      apply_stimulus(lane0(W'(i)), 6'h3F, 1'b0, 1'b0);
    end
    drain();
    check_output("bp_outputs", 32'(out_count - base), 32'd6);

    // Counter saturation with a long packet.
    for (int i = 0; i < 301; i++) begin
      apply_stimulus(lane0(4'h1), 6'h01, 1'b1, (i == 300));
    end
    drain();

    // Mid-packet reset discards the partial packet.
    base = out_count;
    apply_stimulus(lane0(4'h1), 6'h3F, 1'b1, 1'b0);
    apply_stimulus(lane0(4'h2), 6'h3F, 1'b1, 1'b0);
    idle(1);
    @(negedge iclk);
    ivalid = 1'b0;
    iready = 1'b0;
    irst_n = 1'b0;
    #1;
    check_output("rst_ovalid", 32'(ovalid), 32'd0);
    check_output("rst_oready", 32'(oready), 32'd1);
    m_in_pkt = 0;
    m_acc = '0;
    m_cnt = 0;
    @(negedge iclk);
    irst_n = 1'b1;
    iready = 1'b1;
    check_output("rst_no_output", 32'(out_count - base), 32'd0);
    apply_stimulus(lane0(4'hA), 6'h3F, 1'b1, 1'b1);
    drain();

    // Random soak with random backpressure.
    random_bp = 1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
      lst = (i == 399) ? 1'b1 : ($urandom_range(0, 3) == 0);
      apply_stimulus(d, N'($urandom), 1'($urandom), lst);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain();
    check_output("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
